// File: rtl/histogram_ctrl_if.sv
// Bundle of the sample stream, bin readout stream, bin RAM port and frame interrupt
// used by histogram_ctrl; slave is the controller side, master the environment side.
interface histogram_ctrl_if #(
    parameter int P_DW      = 4,
    parameter int P_NUM_BIN = 8,
    parameter int P_CW      = 16
);
    localparam int AW = $clog2(P_NUM_BIN);

    logic [P_DW-1:0] rdata;
    logic            rvalid;
    logic            rlast;
    logic            rready;

    logic [P_CW-1:0] tdata;
    logic            tvalid;
    logic            tlast;
    logic            tready;

    logic [AW-1:0]   bin_addr;
    logic            bin_rd_en;
    logic            bin_we;
    logic [P_CW-1:0] bin_wdata;
    logic [P_CW-1:0] bin_rdata;

    logic            interrupt_out;

    modport slave (
        input  rdata, rvalid, rlast, tready, bin_rdata,
        output rready, tdata, tvalid, tlast,
        output bin_addr, bin_rd_en, bin_we, bin_wdata, interrupt_out
    );

    modport master (
        output rdata, rvalid, rlast, tready, bin_rdata,
        input  rready, tdata, tvalid, tlast,
        input  bin_addr, bin_rd_en, bin_we, bin_wdata, interrupt_out
    );
endinterface

// File: rtl/histogram_ctrl.sv
// Histogram controller: clears bin RAM, accumulates one sample per two cycles, streams bins out.
// Optional macro HISTOGRAM_CLEAR_ON_READ_EN zeroes bins during readout and skips the per-frame CLEAR.
module histogram_ctrl #(
    parameter int P_DW      = 4,
    parameter int P_NUM_BIN = 8,
    parameter int P_CW      = 16
) (
    input logic             aclk,
    input logic             areset_n,
    histogram_ctrl_if.slave bus
);
    localparam int AW = $clog2(P_NUM_BIN);
    localparam logic [AW-1:0]   LAST_BIN = AW'(P_NUM_BIN - 1);
    localparam logic [P_CW-1:0] CNT_MAX  = '1;

    localparam logic [2:0] ST_CLEAR   = 3'd0;
    localparam logic [2:0] ST_ACC     = 3'd1;
    localparam logic [2:0] ST_ACC_WR  = 3'd2;
    localparam logic [2:0] ST_RO_REQ  = 3'd3;
    localparam logic [2:0] ST_RO_LOAD = 3'd4;
    localparam logic [2:0] ST_RO_SEND = 3'd5;
    localparam logic [2:0] ST_DONE    = 3'd6;

    logic [2:0]      state;
    logic [AW-1:0]   cnt;
    logic [AW-1:0]   idx_q;
    logic            last_q;
    logic            active;
    logic [P_CW-1:0] tdata_q;
    logic [AW-1:0]   bin_sel;
    logic [P_CW-1:0] bin_inc;

    assign bin_sel = bus.rdata[P_DW-1 -: AW];
    assign bin_inc = (bus.bin_rdata == CNT_MAX) ? CNT_MAX : bus.bin_rdata + P_CW'(1);

    // active stays low for the cycle following a reset edge so every output is quiet then
    always_ff @(posedge aclk) begin
        if (!areset_n) begin
            state   <= ST_CLEAR;
            cnt     <= '0;
            idx_q   <= '0;
            last_q  <= 1'b0;
            active  <= 1'b0;
            tdata_q <= '0;
        end else begin
            active <= 1'b1;
            case (state)
                ST_CLEAR: begin
                    if (active) begin
                        if (cnt == LAST_BIN) begin
                            cnt   <= '0;
                            state <= ST_ACC;
                        end else begin
                            cnt <= cnt + AW'(1);
                        end
                    end
                end
                ST_ACC: begin
                    if (bus.rvalid) begin
                        idx_q  <= bin_sel;
                        last_q <= bus.rlast;
                        state  <= ST_ACC_WR;
                    end
                end
                ST_ACC_WR:  state <= last_q ? ST_RO_REQ : ST_ACC;
                ST_RO_REQ:  state <= ST_RO_LOAD;
                ST_RO_LOAD: begin
                    tdata_q <= bus.bin_rdata;
                    state   <= ST_RO_SEND;
                end
                ST_RO_SEND: begin
                    if (bus.tready) begin
                        if (cnt == LAST_BIN) begin
                            cnt   <= '0;
                            state <= ST_DONE;
                        end else begin
                            cnt   <= cnt + AW'(1);
                            state <= ST_RO_REQ;
                        end
                    end
                end
`ifdef HISTOGRAM_CLEAR_ON_READ_EN
                ST_DONE:    state <= ST_ACC;
`else
                ST_DONE:    state <= ST_CLEAR;
`endif
                default:    state <= ST_CLEAR;
            endcase
        end
    end

    always_comb begin
        bus.rready        = 1'b0;
        bus.tdata         = tdata_q;
        bus.tvalid        = 1'b0;
        bus.tlast         = 1'b0;
        bus.bin_addr      = '0;
        bus.bin_rd_en     = 1'b0;
        bus.bin_we        = 1'b0;
        bus.bin_wdata     = '0;
        bus.interrupt_out = 1'b0;
        case (state)
            ST_CLEAR: begin
                if (active) begin
                    bus.bin_we   = 1'b1;
                    bus.bin_addr = cnt;
                end
            end
            ST_ACC: begin
                bus.rready    = 1'b1;
                bus.bin_rd_en = bus.rvalid;
                bus.bin_addr  = bin_sel;
            end
            ST_ACC_WR: begin
                bus.bin_we    = 1'b1;
                bus.bin_addr  = idx_q;
                bus.bin_wdata = bin_inc;
            end
            ST_RO_REQ: begin
                bus.bin_rd_en = 1'b1;
                bus.bin_addr  = cnt;
            end
            ST_RO_LOAD: begin
`ifdef HISTOGRAM_CLEAR_ON_READ_EN
                bus.bin_we   = 1'b1;
                bus.bin_addr = cnt;
`endif
            end
            ST_RO_SEND: begin
                bus.tvalid = 1'b1;
                bus.tlast  = (cnt == LAST_BIN);
            end
            ST_DONE:    bus.interrupt_out = 1'b1;
            default: ;
        endcase
    end
endmodule

// File: tb/tb_histogram_ctrl.sv
// Directed self-checking bench for histogram_ctrl with P_DW=4, P_NUM_BIN=8, P_CW=8 and a 1-cycle bin RAM model.
module tb_histogram_ctrl;
    logic aclk = 1'b0;
    logic areset_n = 1'b0;
    always #5 aclk = ~aclk;

    histogram_ctrl_if #(.P_DW(4), .P_NUM_BIN(8), .P_CW(8)) bus ();

    histogram_ctrl #(.P_DW(4), .P_NUM_BIN(8), .P_CW(8)) dut (
        .aclk     (aclk),
        .areset_n (areset_n),
        .bus      (bus)
    );

`ifdef HISTOGRAM_CLEAR_ON_READ_EN
    localparam int GAP_WRITES = 0;
    localparam int GAP_CYCLES = 1;
`else
    localparam int GAP_WRITES = 8;
    localparam int GAP_CYCLES = 9;
`endif

    logic [7:0] mem [8];
    int total = 0;
    int bad = 0;
    int zeroWrites = 0;
    int intCount = 0;
    int zBase = 0;
    int intBase = 0;

    always @(posedge aclk) begin
        if (bus.bin_we) mem[bus.bin_addr] <= bus.bin_wdata;
        if (bus.bin_rd_en) bus.bin_rdata <= mem[bus.bin_addr];
        if (bus.bin_we && bus.bin_wdata == 8'd0) zeroWrites++;
        if (bus.interrupt_out) intCount++;
    end

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total++;
        assert (observed === expected) else begin
            bad++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    function automatic logic [31:0] outVec();
        return 32'({bus.rready, bus.tvalid, bus.tlast, bus.tdata, bus.bin_we,
                    bus.bin_rd_en, bus.bin_addr, bus.bin_wdata, bus.interrupt_out});
    endfunction

    task automatic applyStimulus(input logic [3:0] d, input logic last);
        bus.rdata  = d;
        bus.rlast  = last;
        bus.rvalid = 1'b1;
        #1;
        for (int n = 0; n < 20 && !bus.rready; n++) tick();
        if (!bus.rready) checkOutput("rready_wait", 32'(bus.rready), 32'd1);
        tick();
        bus.rvalid = 1'b0;
        bus.rlast  = 1'b0;
    endtask

    task automatic waitTvalid(input int b);
        for (int n = 0; n < 20 && !bus.tvalid; n++) tick();
        checkOutput($sformatf("tvalid_beat%0d", b), 32'(bus.tvalid), 32'd1);
    endtask

    task automatic checkClear();
        tick();
        for (int k = 0; k < 8; k++) begin
            checkOutput($sformatf("clear%0d", k),
                        32'({bus.bin_we, bus.bin_addr, bus.bin_wdata, bus.rready}),
                        32'({1'b1, 3'(k), 8'h00, 1'b0}));
            tick();
        end
        checkOutput("rready_after_clear", 32'(bus.rready), 32'd1);
    endtask

    // Leaves the bench sitting in the DONE cycle of the frame
    task automatic readFrame(input logic [63:0] expData, input int stallBeat);
        logic [7:0] e;
        intBase = intCount;
        for (int b = 0; b < 8; b++) begin
            e = expData[b*8 +: 8];
            waitTvalid(b);
            checkOutput($sformatf("tdata_beat%0d", b), 32'(bus.tdata), 32'(e));
            checkOutput($sformatf("tlast_beat%0d", b), 32'(bus.tlast), 32'(b == 7));
            if (b == stallBeat) begin
                for (int s = 0; s < 5; s++) begin
                    tick();
                    checkOutput($sformatf("stall%0d", s),
                                32'({bus.tvalid, bus.tlast, bus.tdata}),
                                32'({1'b1, 1'(b == 7), e}));
                end
            end
            bus.tready = 1'b1;
            tick();
            bus.tready = 1'b0;
        end
        checkOutput("irq_pulse", 32'({bus.interrupt_out, 8'(intCount - intBase)}), 32'({1'b1, 8'd0}));
        zBase = zeroWrites;
    endtask

    task automatic waitAcc();
        int cycles;
        cycles = 1;
        tick();
        checkOutput("irq_single", 32'({bus.interrupt_out, 8'(intCount - intBase)}), 32'({1'b0, 8'd1}));
        while (!bus.rready && cycles < 40) begin
            tick();
            cycles++;
        end
        checkOutput("gap_rready", 32'(bus.rready), 32'd1);
        checkOutput("gap_cycles", 32'(cycles), 32'(GAP_CYCLES));
        checkOutput("gap_clear_writes", 32'(zeroWrites - zBase), 32'(GAP_WRITES));
    endtask

    initial begin
        bus.rdata  = 4'h0;
        bus.rvalid = 1'b0;
        bus.rlast  = 1'b0;
        bus.tready = 1'b0;

        tick();
        tick();
        checkOutput("reset_outputs", outVec(), 32'd0);
        tick();
        checkOutput("reset_held", outVec(), 32'd0);
        areset_n = 1'b1;
        checkClear();

        // bins 1,1,7 -> counts 2 and 1; stray rlast without rvalid is ignored
        applyStimulus(4'h3, 1'b0);
        applyStimulus(4'h2, 1'b0);
        tick();
        bus.rlast = 1'b1;
        tick();
        tick();
        bus.rlast = 1'b0;
        checkOutput("rlast_ignored", 32'({bus.tvalid, bus.rready}), 32'({1'b0, 1'b1}));
        applyStimulus(4'hF, 1'b1);
        readFrame(64'h01_00_00_00_00_00_02_00, -1);
        waitAcc();

        for (int n = 0; n < 299; n++) applyStimulus(4'h0, 1'b0);
        applyStimulus(4'h0, 1'b1);
        readFrame(64'h00_00_00_00_00_00_00_FF, -1);
        waitAcc();

        applyStimulus(4'h5, 1'b0);
        applyStimulus(4'h9, 1'b1);
        readFrame(64'h00_00_00_01_00_01_00_00, 2);
        waitAcc();

        // abort during beat 4 of a frame holding a single count in bin 3
        applyStimulus(4'h7, 1'b1);
        intBase = intCount;
        for (int b = 0; b < 3; b++) begin
            waitTvalid(b);
            bus.tready = 1'b1;
            tick();
            bus.tready = 1'b0;
        end
        waitTvalid(3);
        checkOutput("abort_beat_data", 32'(bus.tdata), 32'd1);
        areset_n = 1'b0;
        tick();
        checkOutput("abort_outputs", outVec(), 32'd0);
        tick();
        checkOutput("abort_no_irq", 32'(intCount - intBase), 32'd0);
        areset_n = 1'b1;
        checkClear();

        applyStimulus(4'h4, 1'b1);
        readFrame(64'h00_00_00_00_00_01_00_00, -1);
        waitAcc();
        applyStimulus(4'h4, 1'b1);
        readFrame(64'h00_00_00_00_00_01_00_00, -1);
        waitAcc();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
